// File: rtl/imem_loader_if.sv
// Loader-side bundle: byte stream in, program-memory write port and CPU status out.
// The loader attaches to the slave modport. The stream source and status consumer attach to master.
interface imem_loader_if #(
    parameter int AW = 4,
    parameter int DW = 18
);
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, busy, done, error, words_loaded
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Fills CPU program memory from a byte stream (LEN, then 3 bytes per 18-bit word) and stalls the CPU until a clean load.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over LEN and all data bytes.
module imem_loader #(
    parameter int AW = 4,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    localparam int         DEPTH  = 1 << AW;
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_B0, S_B1, S_B2, S_WRITE, S_DONE, S_ERROR, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_B0, S_B1, S_B2, S_WRITE, S_DONE, S_ERROR
    } state_t;
`endif

    state_t        r_state;
    logic [7:0]    r_len;
    logic [1:0]    r_hi;
    logic [7:0]    r_mid;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_cpu_hold;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [AW:0]   r_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    logic w_ready;
    logic w_accept;
    logic w_len_big;
    logic w_last;

    // Ready depends on state only so the source may hold valid without a combinational loop.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_LEN, S_B0, S_B1, S_B2: w_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:                  w_ready = 1'b1;
`endif
            default:                 w_ready = 1'b0;
        endcase
    end

    assign w_accept  = w_ready & bus.rx_valid;
    assign w_len_big = {1'b0, bus.rx_data} > DEPTH9;
    assign w_last    = (9'(r_words) + 9'd1) == {1'b0, r_len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_hi        <= '0;
            r_mid       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_words     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_LEN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_mem_addr <= '0;
                        r_words    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_len <= bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.rx_data;
`endif
                        if (bus.rx_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CSUM;
`else
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                            r_busy     <= 1'b0;
`endif
                        end else if (w_len_big) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_B0;
                        end
                    end
                end
                S_B0: begin
                    if (w_accept) begin
                        r_hi    <= bus.rx_data[1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= r_csum ^ bus.rx_data;
`endif
                        r_state <= S_B1;
                    end
                end
                S_B1: begin
                    if (w_accept) begin
                        r_mid   <= bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= r_csum ^ bus.rx_data;
`endif
                        r_state <= S_B2;
                    end
                end
                S_B2: begin
                    if (w_accept) begin
                        r_mem_wdata <= DW'({r_hi, r_mid, bus.rx_data});
                        r_mem_we    <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum      <= r_csum ^ bus.rx_data;
`endif
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally to 0 after a full-depth load.
                    r_mem_addr <= r_mem_addr + 1'b1;
                    r_words    <= r_words + 1'b1;
                    if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state    <= S_CSUM;
`else
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                        r_busy     <= 1'b0;
`endif
                    end else begin
                        r_state <= S_B0;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_accept) begin
                        if (bus.rx_data == r_csum) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                        r_busy <= 1'b0;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                S_ERROR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready     = w_ready;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.cpu_hold     = r_cpu_hold;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a word-level model of the stream format predicts writes and final status.
// Covers reset idle, basic/full-depth/oversize/empty loads, backpressure with stray starts, and mid-load reset.
module tb_imem_loader;
    localparam int AW    = 4;
    localparam int DW    = 18;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.AW(AW), .DW(DW)) bus ();

    imem_loader #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp    = 0;
    int n_bad    = 0;
    int we_count = 0;
    int we_long  = 0;
    logic prev_we = 1'b0;

    logic [7:0] s_b0 [256];
    logic [7:0] s_b1 [256];
    logic [7:0] s_b2 [256];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_count++;
            if (prev_we) we_long++;
        end
        prev_we = (bus.mem_we === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offers one byte after a random idle gap; stray start pulses during the gap must be ignored.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int n;
        int t;
        n = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int g = 0; g < n; g++) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            bus.start    = ($urandom_range(3, 0) == 0);
            @(negedge clk);
        end
        bus.start    = 1'b0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        t = 0;
        while (bus.rx_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("rx_ready_timeout", 32'(0), 32'(1));
        else          @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input int k, input int gap, input string tag);
        logic [17:0] w;
        send_byte(s_b0[k], gap);
        send_byte(s_b1[k], gap);
        send_byte(s_b2[k], gap);
        w = {s_b0[k][1:0], s_b1[k], s_b2[k]};
        chk($sformatf("%s_we_w%0d", tag, k),   32'(bus.mem_we),    32'(1));
        chk($sformatf("%s_addr_w%0d", tag, k), 32'(bus.mem_addr),  32'(k % DEPTH));
        chk($sformatf("%s_data_w%0d", tag, k), 32'(bus.mem_wdata), 32'(w));
    endtask

    task automatic run_load(input int len, input int gap, input logic bad_csum, input string tag);
        int         we0;
        logic [7:0] cs;
        logic       ok;
        we0 = we_count;
        do_start();
        chk({tag, "_busy"}, 32'(bus.busy), 32'(1));
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(1));
        send_byte(8'(len), gap);
        cs = 8'(len);
        if (len > DEPTH) begin
            tick(2);
            chk({tag, "_error"}, 32'(bus.error), 32'(1));
            chk({tag, "_done"},  32'(bus.done), 32'(0));
            chk({tag, "_hold"},  32'(bus.cpu_hold), 32'(1));
            chk({tag, "_idle"},  32'(bus.busy), 32'(0));
            chk({tag, "_words"}, 32'(bus.words_loaded), 32'(0));
            chk({tag, "_nwe"},   32'(we_count - we0), 32'(0));
        end else begin
            for (int k = 0; k < len; k++) begin
                send_word(k, gap, tag);
                cs = cs ^ s_b0[k] ^ s_b1[k] ^ s_b2[k];
            end
            ok = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (bad_csum) send_byte(cs ^ 8'($urandom_range(255, 1)), gap);
            else          send_byte(cs, gap);
            ok = !bad_csum;
`else
            if (bad_csum) ok = 1'b1;
`endif
            tick(2);
            chk({tag, "_done"},  32'(bus.done), 32'(ok));
            chk({tag, "_error"}, 32'(bus.error), 32'(!ok));
            chk({tag, "_hold"},  32'(bus.cpu_hold), 32'(!ok));
            chk({tag, "_idle"},  32'(bus.busy), 32'(0));
            chk({tag, "_words"}, 32'(bus.words_loaded), 32'(len));
            chk({tag, "_addr"},  32'(bus.mem_addr), 32'(len % DEPTH));
            chk({tag, "_nwe"},   32'(we_count - we0), 32'(len));
        end
    endtask

    initial begin
        int len;
        int we0;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        rst_n        = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("rst_hold",  32'(bus.cpu_hold), 32'(1));
        chk("rst_done",  32'(bus.done), 32'(0));
        chk("rst_error", 32'(bus.error), 32'(0));
        chk("rst_busy",  32'(bus.busy), 32'(0));
        chk("rst_ready", 32'(bus.rx_ready), 32'(0));
        chk("rst_words", 32'(bus.words_loaded), 32'(0));
        chk("rst_nwe",   32'(we_count), 32'(0));

        s_b0[0] = 8'h03; s_b1[0] = 8'hFF; s_b2[0] = 8'hFF;
        s_b0[1] = 8'h00; s_b1[1] = 8'h12; s_b2[1] = 8'h34;
        run_load(2, 0, 1'b0, "basic");

        for (int k = 0; k < DEPTH; k++) begin
            s_b0[k] = 8'h00; s_b1[k] = 8'h00; s_b2[k] = 8'(k);
        end
        run_load(DEPTH, 0, 1'b0, "full");
        run_load(DEPTH + 1, 0, 1'b0, "oversize");
        run_load(0, 0, 1'b0, "empty");

        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(DEPTH, 1));
            for (int k = 0; k < len; k++) begin
                s_b0[k] = 8'($urandom); s_b1[k] = 8'($urandom); s_b2[k] = 8'($urandom);
            end
            run_load(len, 3, 1'b0, $sformatf("rand%0d", r));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        s_b0[0] = 8'h03; s_b1[0] = 8'hFF; s_b2[0] = 8'hFF;
        s_b0[1] = 8'h00; s_b1[1] = 8'h12; s_b2[1] = 8'h34;
        run_load(2, 0, 1'b1, "csum_bad");
`endif

        // Backpressured 3-word load cut short by reset after the second write.
        for (int k = 0; k < 3; k++) begin
            s_b0[k] = 8'($urandom); s_b1[k] = 8'($urandom); s_b2[k] = 8'($urandom);
        end
        do_start();
        send_byte(8'd3, 3);
        send_word(0, 3, "bp");
        send_word(1, 3, "bp");
        send_byte(s_b0[2], 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_hold",  32'(bus.cpu_hold), 32'(1));
        chk("mrst_busy",  32'(bus.busy), 32'(0));
        chk("mrst_done",  32'(bus.done), 32'(0));
        chk("mrst_error", 32'(bus.error), 32'(0));
        chk("mrst_ready", 32'(bus.rx_ready), 32'(0));
        chk("mrst_we",    32'(bus.mem_we), 32'(0));
        chk("mrst_addr",  32'(bus.mem_addr), 32'(0));
        chk("mrst_wdata", 32'(bus.mem_wdata), 32'(0));
        chk("mrst_words", 32'(bus.words_loaded), 32'(0));
        we0 = we_count;
        @(negedge clk);
        rst_n = 1'b1;
        bus.rx_valid = 1'b1;
        tick(5);
        bus.rx_valid = 1'b0;
        chk("post_rst_nwe",  32'(we_count - we0), 32'(0));
        chk("post_rst_busy", 32'(bus.busy), 32'(0));
        chk("we_pulse_width", 32'(we_long), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
